// File: rtl/axi4_ar_arbiter.sv
// Purpose: shares one AXI4 read path (AR+R) among NUM_REQ requesters, round-robin AR arbitration with ID prefixing.
// Latency: s_AR accept to m_ARVALID is 1 cycle; the R path is purely combinational.
// Backpressure: the held AR waits for m_ARREADY, and the per-requester outstanding limit masks requests. Optional macro AXI4_ARB_QOS_EN.
module axi4_ar_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic [NUM_REQ-1:0]                    s_ARVALID,
  output logic [NUM_REQ-1:0]                    s_ARREADY,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]         s_ARADDR,
  input  logic [NUM_REQ*8-1:0]                  s_ARLEN,
  input  logic [NUM_REQ*3-1:0]                  s_ARSIZE,
  input  logic [NUM_REQ*2-1:0]                  s_ARBURST,
  input  logic [NUM_REQ*ID_WIDTH-1:0]           s_ARID,
  input  logic [NUM_REQ*4-1:0]                  s_ARQOS,
  output logic [NUM_REQ-1:0]                    s_RVALID,
  input  logic [NUM_REQ-1:0]                    s_RREADY,
  output logic [DATA_WIDTH-1:0]                 s_RDATA,
  output logic [1:0]                            s_RRESP,
  output logic                                  s_RLAST,
  output logic [ID_WIDTH-1:0]                   s_RID,
  output logic                                  m_ARVALID,
  input  logic                                  m_ARREADY,
  output logic [ADDR_WIDTH-1:0]                 m_ARADDR,
  output logic [7:0]                            m_ARLEN,
  output logic [2:0]                            m_ARSIZE,
  output logic [1:0]                            m_ARBURST,
  output logic [3:0]                            m_ARQOS,
  output logic [ID_WIDTH+$clog2(NUM_REQ)-1:0]   m_ARID,
  input  logic                                  m_RVALID,
  output logic                                  m_RREADY,
  input  logic [DATA_WIDTH-1:0]                 m_RDATA,
  input  logic [1:0]                            m_RRESP,
  input  logic                                  m_RLAST,
  input  logic [ID_WIDTH+$clog2(NUM_REQ)-1:0]   m_RID,
  output logic                                  err_resp
);
  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int MID_W = ID_WIDTH + SEL_W;
  localparam logic [SEL_W:0] NUM_REQ_W = (SEL_W+1)'(NUM_REQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [2:0]              arsize_q, arsize_d;
  logic [1:0]              arburst_q, arburst_d;
  logic [3:0]              arqos_q, arqos_d;
  logic [MID_W-1:0]        arid_q, arid_d;
  logic [SEL_W-1:0]        last_grant_q, last_grant_d;
  logic [7:0]              cnt_q [NUM_REQ];
  logic [7:0]              cnt_d [NUM_REQ];
  logic                    err_q, err_d;

  logic [SEL_W-1:0]        gnt_idx, r_idx, winner;
  logic [NUM_REQ-1:0]      inc, dec, elig;
  logic                    any_elig, take, ar_hs, r_oob, under;

  assign m_ARVALID = arvalid_q;
  assign m_ARADDR  = araddr_q;
  assign m_ARLEN   = arlen_q;
  assign m_ARSIZE  = arsize_q;
  assign m_ARBURST = arburst_q;
  assign m_ARQOS   = arqos_q;
  assign m_ARID    = arid_q;
  assign err_resp  = err_q;

  assign gnt_idx = arid_q[ID_WIDTH +: SEL_W];
  assign ar_hs   = arvalid_q && m_ARREADY;
  assign take    = ((state_q == IDLE) || m_ARREADY) && any_elig;
  assign r_idx   = m_RID[ID_WIDTH +: SEL_W];
  assign r_oob   = {1'b0, r_idx} >= NUM_REQ_W;

  assign s_RDATA = m_RDATA;
  assign s_RRESP = m_RRESP;
  assign s_RLAST = m_RLAST;
  assign s_RID   = m_RID[ID_WIDTH-1:0];

  // Eligibility: the slot issued this cycle already counts against its requester's limit.
  always_comb begin
    inc  = '0;
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc[i]  = ar_hs && (gnt_idx == SEL_W'(i));
      elig[i] = s_ARVALID[i] && (({1'b0, cnt_q[i]} + {8'd0, inc[i]}) < 9'(MAX_OUTSTANDING));
    end
  end

  // Winner search starting just after the last grant, wrapping around.
  always_comb begin : p_winner
    int j;
`ifdef AXI4_ARB_QOS_EN
    logic [3:0] best_qos;
    best_qos = '0;
`endif
    j        = 0;
    any_elig = 1'b0;
    winner   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_grant_q) + k) % NUM_REQ;
`ifdef AXI4_ARB_QOS_EN
      // Strictly-greater keeps the first requester in round-robin order among equal QoS.
      if (elig[j] && (!any_elig || (s_ARQOS[j*4 +: 4] > best_qos))) begin
        any_elig = 1'b1;
        winner   = SEL_W'(j);
        best_qos = s_ARQOS[j*4 +: 4];
      end
`else
      if (elig[j] && !any_elig) begin
        any_elig = 1'b1;
        winner   = SEL_W'(j);
      end
`endif
    end
  end

  // One-hot accept towards the winning requester.
  always_comb begin
    s_ARREADY = '0;
    if (take) s_ARREADY[winner] = 1'b1;
  end

  // AR FSM next state and payload capture.
  always_comb begin : p_fsm
    int w;
    w            = int'(winner);
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    arqos_d      = arqos_q;
    arid_d       = arid_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: ;
      HOLD: if (m_ARREADY && !any_elig) begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
      end
    endcase
    if (take) begin
      state_d      = HOLD;
      arvalid_d    = 1'b1;
      araddr_d     = s_ARADDR[w*ADDR_WIDTH +: ADDR_WIDTH];
      arlen_d      = s_ARLEN[w*8 +: 8];
      arsize_d     = s_ARSIZE[w*3 +: 3];
      arburst_d    = s_ARBURST[w*2 +: 2];
      arqos_d      = s_ARQOS[w*4 +: 4];
      arid_d       = {winner, s_ARID[w*ID_WIDTH +: ID_WIDTH]};
      last_grant_d = winner;
    end
  end

  // R routing by the ID prefix; unmapped prefixes are always accepted and dropped.
  always_comb begin
    s_RVALID = '0;
    dec      = '0;
    m_RREADY = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_idx == SEL_W'(i)) begin
        s_RVALID[i] = m_RVALID;
        m_RREADY    = s_RREADY[i];
        dec[i]      = m_RVALID && s_RREADY[i] && m_RLAST;
      end
    end
  end

  // Outstanding counters; a decrement at zero saturates and flags an error.
  always_comb begin
    under = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == 8'd0) under = 1'b1;
        else                  cnt_d[i] = cnt_q[i] - 8'd1;
      end
    end
    err_d = (m_RVALID && r_oob) || under;
  end

  // State registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arqos_q      <= '0;
      arid_q       <= '0;
      last_grant_q <= SEL_W'(NUM_REQ-1);
      err_q        <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arqos_q      <= arqos_d;
      arid_q       <= arid_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: tb/tb_axi4_ar_arbiter.sv
// Purpose: directed checks of AR arbitration, R routing and outstanding limits of axi4_ar_arbiter.
// Latency: expected AR beats are queued at the accept cycle and compared on the master handshake.
// Backpressure: m_ARREADY stalls, per-requester limits and s_RREADY routing are exercised.
module tb_axi4_ar_arbiter;
  localparam int N  = 4;
  localparam int NB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MW = 6;

  logic ACLK = 1'b0;
  logic ARESET = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [N-1:0]    s_ARVALID = '0, s_ARREADY, s_RVALID, s_RREADY = '1;
  logic [N*AW-1:0] s_ARADDR;
  logic [N*8-1:0]  s_ARLEN;
  logic [N*3-1:0]  s_ARSIZE;
  logic [N*2-1:0]  s_ARBURST;
  logic [N*IW-1:0] s_ARID;
  logic [N*4-1:0]  s_ARQOS;
  logic [DW-1:0]   s_RDATA;
  logic [1:0]      s_RRESP;
  logic            s_RLAST;
  logic [IW-1:0]   s_RID;
  logic            m_ARVALID, m_ARREADY = 1'b0;
  logic [AW-1:0]   m_ARADDR;
  logic [7:0]      m_ARLEN;
  logic [2:0]      m_ARSIZE;
  logic [1:0]      m_ARBURST;
  logic [3:0]      m_ARQOS;
  logic [MW-1:0]   m_ARID;
  logic            m_RVALID = 1'b0, m_RREADY;
  logic [DW-1:0]   m_RDATA = '0;
  logic [1:0]      m_RRESP = '0;
  logic            m_RLAST = 1'b0;
  logic [MW-1:0]   m_RID = '0;
  logic            err_resp;

  logic [31:0] req_addr [N];
  logic [3:0]  req_qos  [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign s_ARADDR[g*AW +: AW]  = req_addr[g];
    assign s_ARID[g*IW +: IW]    = 4'(g + 5);
    assign s_ARLEN[g*8 +: 8]     = 8'(g + 1);
    assign s_ARSIZE[g*3 +: 3]    = 3'd2;
    assign s_ARBURST[g*2 +: 2]   = 2'b01;
    assign s_ARQOS[g*4 +: 4]     = req_qos[g];
  end

  axi4_ar_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN),
    .s_ARSIZE(s_ARSIZE), .s_ARBURST(s_ARBURST), .s_ARID(s_ARID), .s_ARQOS(s_ARQOS),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
    .s_RLAST(s_RLAST), .s_RID(s_RID),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN),
    .m_ARSIZE(m_ARSIZE), .m_ARBURST(m_ARBURST), .m_ARQOS(m_ARQOS), .m_ARID(m_ARID),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP),
    .m_RLAST(m_RLAST), .m_RID(m_RID), .err_resp(err_resp)
  );

  // Three-requester instance: prefix 3 is unmapped.
  logic [NB-1:0]    b_s_ARVALID = '0, b_s_ARREADY, b_s_RVALID, b_s_RREADY = '0;
  logic [NB*AW-1:0] b_s_ARADDR = '0;
  logic [NB*8-1:0]  b_s_ARLEN = '0;
  logic [NB*3-1:0]  b_s_ARSIZE = '0;
  logic [NB*2-1:0]  b_s_ARBURST = '0;
  logic [NB*IW-1:0] b_s_ARID = '0;
  logic [NB*4-1:0]  b_s_ARQOS = '0;
  logic [DW-1:0]    b_s_RDATA;
  logic [1:0]       b_s_RRESP;
  logic             b_s_RLAST;
  logic [IW-1:0]    b_s_RID;
  logic             b_m_ARVALID, b_m_ARREADY = 1'b0;
  logic [AW-1:0]    b_m_ARADDR;
  logic [7:0]       b_m_ARLEN;
  logic [2:0]       b_m_ARSIZE;
  logic [1:0]       b_m_ARBURST;
  logic [3:0]       b_m_ARQOS;
  logic [MW-1:0]    b_m_ARID;
  logic             b_m_RVALID = 1'b0, b_m_RREADY;
  logic [DW-1:0]    b_m_RDATA = '0;
  logic [1:0]       b_m_RRESP = '0;
  logic             b_m_RLAST = 1'b0;
  logic [MW-1:0]    b_m_RID = '0;
  logic             b_err;

  axi4_ar_arbiter #(.NUM_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(8)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_ARVALID(b_s_ARVALID), .s_ARREADY(b_s_ARREADY), .s_ARADDR(b_s_ARADDR), .s_ARLEN(b_s_ARLEN),
    .s_ARSIZE(b_s_ARSIZE), .s_ARBURST(b_s_ARBURST), .s_ARID(b_s_ARID), .s_ARQOS(b_s_ARQOS),
    .s_RVALID(b_s_RVALID), .s_RREADY(b_s_RREADY), .s_RDATA(b_s_RDATA), .s_RRESP(b_s_RRESP),
    .s_RLAST(b_s_RLAST), .s_RID(b_s_RID),
    .m_ARVALID(b_m_ARVALID), .m_ARREADY(b_m_ARREADY), .m_ARADDR(b_m_ARADDR), .m_ARLEN(b_m_ARLEN),
    .m_ARSIZE(b_m_ARSIZE), .m_ARBURST(b_m_ARBURST), .m_ARQOS(b_m_ARQOS), .m_ARID(b_m_ARID),
    .m_RVALID(b_m_RVALID), .m_RREADY(b_m_RREADY), .m_RDATA(b_m_RDATA), .m_RRESP(b_m_RRESP),
    .m_RLAST(b_m_RLAST), .m_RID(b_m_RID), .err_resp(b_err)
  );

  typedef struct packed {
    logic [MW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [3:0]    qos;
  } ar_t;

  ar_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ar_t exp_for(input int i);
    ar_t e;
    e.id   = {2'(i), 4'(i + 5)};
    e.addr = req_addr[i];
    e.len  = 8'(i + 1);
    e.qos  = req_qos[i];
    return e;
  endfunction

  // One cycle: check accepts and m_ARVALID, retire a master handshake against the queue, queue new accepts.
  task automatic step(input logic [N-1:0] exp_ardy, input logic exp_mv);
    ar_t e;
    #1;
    chk("s_ARREADY", 64'(s_ARREADY), 64'(exp_ardy));
    chk("m_ARVALID", 64'(m_ARVALID), 64'(exp_mv));
    if (m_ARVALID && m_ARREADY) begin
      chk("ar_sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_ARID", 64'(m_ARID), 64'(e.id));
        chk("m_ARADDR", 64'(m_ARADDR), 64'(e.addr));
        chk("m_ARLEN", 64'(m_ARLEN), 64'(e.len));
        chk("m_ARQOS", 64'(m_ARQOS), 64'(e.qos));
      end
    end
    for (int i = 0; i < N; i++) if (exp_ardy[i]) exp_q.push_back(exp_for(i));
    @(posedge ACLK); #1;
  endtask

  task automatic do_reset();
    ARESET    = 1'b1;
    s_ARVALID = '0;
    m_ARREADY = 1'b0;
    m_RVALID  = 1'b0;
    m_RLAST   = 1'b0;
    m_RID     = '0;
    s_RREADY  = '1;
    exp_q.delete();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  initial begin
    req_addr = '{32'h0000_0A00, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    req_qos  = '{4'd0, 4'd0, 4'd0, 4'd0};
    #1 ARESET = 1'b1;
    #1;
    chk("rst_m_ARVALID", 64'(m_ARVALID), 64'd0);
    chk("rst_m_ARID", 64'(m_ARID), 64'd0);
    chk("rst_m_ARADDR", 64'(m_ARADDR), 64'd0);
    chk("rst_m_ARLEN", 64'(m_ARLEN), 64'd0);
    chk("rst_err_resp", 64'(err_resp), 64'd0);
    chk("rst_s_ARREADY", 64'(s_ARREADY), 64'd0);
    do_reset();

    // Round-robin with all requesters valid and the master always ready.
    s_ARVALID = 4'hF;
    m_ARREADY = 1'b1;
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0001, 1'b1);
    s_ARVALID = 4'h0;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    chk("rr_drained", 64'(exp_q.size()), 64'd0);

    // Master stall holds the payload; reset mid-hold drops it immediately.
    do_reset();
    s_ARVALID = 4'b0010;
    step(4'b0010, 1'b0);
    s_ARVALID = 4'b1101;
    step(4'b0000, 1'b1);
    chk("hold_addr_c1", 64'(m_ARADDR), 64'h1000);
    step(4'b0000, 1'b1);
    chk("hold_addr_c2", 64'(m_ARADDR), 64'h1000);
    chk("hold_id_c2", 64'(m_ARID), 64'(6'b01_0110));
    ARESET = 1'b1;
    #1;
    chk("hold_rst_arvalid", 64'(m_ARVALID), 64'd0);
    chk("hold_rst_araddr", 64'(m_ARADDR), 64'd0);
    do_reset();

    // Outstanding limit of 2 on requester 2, released by a last beat.
    m_ARREADY = 1'b1;
    s_ARVALID = 4'b0100;
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    s_ARVALID = 4'b0101;
    step(4'b0001, 1'b1);
    s_ARVALID = 4'b0100;
    step(4'b0000, 1'b1);
    m_RVALID = 1'b1;
    m_RLAST  = 1'b1;
    m_RID    = {2'd2, 4'h0};
    #1;
    chk("lim_s_RVALID", 64'(s_RVALID), 64'b0100);
    chk("lim_m_RREADY", 64'(m_RREADY), 64'd1);
    step(4'b0000, 1'b0);
    m_RVALID = 1'b0;
    step(4'b0100, 1'b0);
    s_ARVALID = 4'b0000;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    chk("lim_drained", 64'(exp_q.size()), 64'd0);

    // R routing by prefix and backpressure from the selected requester.
    m_RVALID = 1'b1;
    m_RLAST  = 1'b0;
    m_RID    = 6'b01_0011;
    m_RDATA  = 32'hDEAD_BEEF;
    m_RRESP  = 2'b10;
    s_RREADY = 4'b1101;
    #1;
    chk("r_s_RVALID", 64'(s_RVALID), 64'b0010);
    chk("r_s_RID", 64'(s_RID), 64'h3);
    chk("r_m_RREADY_blocked", 64'(m_RREADY), 64'd0);
    chk("r_s_RDATA", 64'(s_RDATA), 64'hDEAD_BEEF);
    chk("r_s_RRESP", 64'(s_RRESP), 64'b10);
    chk("r_s_RLAST", 64'(s_RLAST), 64'd0);
    s_RREADY = 4'hF;
    #1;
    chk("r_m_RREADY_open", 64'(m_RREADY), 64'd1);
    @(posedge ACLK); #1;
    // Last beat for requester 1 with nothing outstanding: underflow.
    m_RLAST = 1'b1;
    #1;
    chk("uf_err_same_cycle", 64'(err_resp), 64'd0);
    @(posedge ACLK); #1;
    // Legal last beat for requester 2 (two outstanding).
    m_RID = {2'd2, 4'h0};
    chk("uf_err_pulse", 64'(err_resp), 64'd1);
    @(posedge ACLK); #1;
    m_RVALID = 1'b0;
    chk("dec_no_err", 64'(err_resp), 64'd0);
    @(posedge ACLK); #1;
    chk("err_idle", 64'(err_resp), 64'd0);

    // Unmapped prefix on the three-requester instance.
    b_m_RVALID = 1'b1;
    b_m_RID    = {2'd3, 4'h1};
    #1;
    chk("oob_m_RREADY", 64'(b_m_RREADY), 64'd1);
    chk("oob_s_RVALID", 64'(b_s_RVALID), 64'd0);
    chk("oob_err_same_cycle", 64'(b_err), 64'd0);
    @(posedge ACLK); #1;
    b_m_RVALID = 1'b0;
    chk("oob_err_pulse", 64'(b_err), 64'd1);
    @(posedge ACLK); #1;
    chk("oob_err_clear", 64'(b_err), 64'd0);
    b_m_RVALID = 1'b1;
    b_m_RID    = {2'd2, 4'h1};
    #1;
    chk("b_s_RVALID_req2", 64'(b_s_RVALID), 64'b100);
    chk("b_m_RREADY_req2", 64'(b_m_RREADY), 64'd0);
    b_m_RVALID = 1'b0;

    // QoS: requester 3 outranks requester 0 only when QoS arbitration is built in.
    do_reset();
    req_qos[0] = 4'd2;
    req_qos[3] = 4'd9;
    m_ARREADY  = 1'b1;
    s_ARVALID  = 4'b1001;
`ifdef AXI4_ARB_QOS_EN
    step(4'b1000, 1'b0);
    s_ARVALID = 4'b0001;
    step(4'b0001, 1'b1);
`else
    step(4'b0001, 1'b0);
    s_ARVALID = 4'b1000;
    step(4'b1000, 1'b1);
`endif
    s_ARVALID = 4'b0000;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    chk("qos_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
